// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the FIFO read-port arbiter: parameter defaults,
// FSM state type and a reference round-robin pick helper.
package fifo_pkg;

    localparam int NREQ_DEF       = 4;
    localparam int MAX_BURST_DEF  = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int NREQ_MAX       = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // First set request at or after rr_ptr, wrapping modulo nreq.
    // Returns rr_ptr when nothing is requested.
    function automatic int rr_pick(input logic [NREQ_MAX-1:0] req,
                                   input int rr_ptr,
                                   input int nreq);
        int pick;
        int idx;
        pick = rr_ptr;
        for (int i = nreq - 1; i >= 0; i--) begin
            idx = (rr_ptr + i) % nreq;
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Bundle of the arbiter's FIFO-side and consumer-side signals.
// slave: the arbiter itself; master: the surrounding FIFO/consumers.
interface fifo_rd_arbiter_if
    import fifo_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDW        = $clog2(NREQ)
) ();

    logic [NREQ-1:0]       req;
    logic                  empty;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_en;
    logic [NREQ-1:0]       gnt;
    logic                  rd_valid;
    logic [IDW-1:0]        rd_id;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    modport master (
        output req, empty, r_data,
        input  r_en, gnt, rd_valid, rd_id, rd_data, busy
    );

    modport slave (
        input  req, empty, r_data,
        output r_en, gnt, rd_valid, rd_id, rd_data, busy
    );

endinterface

// File: rtl/fifo_rd_arbiter_rr_select.sv
// Combinational round-robin selector: rotate the request vector so that
// ptr lands at bit 0, priority-encode the lowest set bit, rotate back.
module fifo_rd_arbiter_rr_select #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    k;
    logic [IDW:0]      sum;

    assign dbl = {req, req};
    assign any = |req;

    // Doubled vector makes the wrap-around rotation a plain index offset.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        logic [IDW:0] pos;
        assign pos     = {1'b0, ptr} + (IDW+1)'(gi);
        assign rot[gi] = dbl[pos];
    end

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = IDW'(i);
            end
        end
    end

    // Rotate back: (ptr + k) modulo NREQ, works for non-power-of-two NREQ.
    always_comb begin
        sum = {1'b0, ptr} + {1'b0, k};
        if (sum >= (IDW+1)'(NREQ)) begin
            idx = IDW'(sum - (IDW+1)'(NREQ));
        end else begin
            idx = sum[IDW-1:0];
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter for the read port of the asynchronous FIFO.
// Grants bursts of up to MAX_BURST accepted reads, qualifies reads with the
// registered empty flag and tags each returned word with its owner.
module fifo_rd_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ       = NREQ_DEF,
    parameter int MAX_BURST  = MAX_BURST_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic            rclk,
    input  logic            rrst_n,
    fifo_rd_arbiter_if.slave bus
);

    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t     state_reg, state_next;
    logic [IDW-1:0] owner_reg, owner_next;
    logic [BW-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
    logic           rd_valid_reg;
    logic [IDW-1:0] rd_id_reg;

    logic           sel_any;
    logic [IDW-1:0] sel_idx;
    logic           req_owner;
    logic           r_en_c;
    logic           accept;
    logic           in_burst;

    fifo_rd_arbiter_rr_select #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_select (
        .req (bus.req),
        .ptr (rr_ptr_reg),
        .any (sel_any),
        .idx (sel_idx)
    );

    assign in_burst  = (state_reg == BURST);
    assign req_owner = bus.req[owner_reg];
    // Read enable follows the owner's request; acceptance matches the
    // pointer handler's advance condition.
    assign r_en_c    = in_burst & req_owner;
    assign accept    = r_en_c & ~bus.empty;

    // Next-state logic: arbitration in IDLE, beat counting and exit in BURST.
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        beat_cnt_next = beat_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (sel_any && !bus.empty) begin
                    owner_next    = sel_idx;
                    beat_cnt_next = '0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
                // Any exit condition, even several at once, advances rr_ptr once.
                if ((accept && (beat_cnt_reg == BW'(MAX_BURST - 1))) ||
                    !req_owner ||
                    (bus.empty && !accept)) begin
                    state_next  = IDLE;
                    rr_ptr_next = (owner_reg == IDW'(NREQ - 1)) ? '0
                                                                : owner_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, owner, burst counter and round-robin pointer registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            beat_cnt_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            beat_cnt_reg <= beat_cnt_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    // Return tag: the FIFO word appears one cycle after its accepted read.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_valid_reg <= 1'b0;
            rd_id_reg    <= '0;
        end else begin
            rd_valid_reg <= accept;
            if (accept) begin
                rd_id_reg <= owner_reg;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign bus.gnt[gi] = in_burst && (owner_reg == IDW'(gi));
    end

    assign bus.r_en     = r_en_c;
    assign bus.busy     = in_burst;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_id    = rd_id_reg;
    assign bus.rd_data  = bus.r_data;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: FIFO model driving empty/r_data, behavioural
// arbitration model checked every cycle, plus directed literal scenarios.
module tb_fifo_rd_arbiter;

    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int DW        = 8;
    localparam int IDW       = $clog2(NREQ);
    localparam int FIFO_CAP  = 16;

    logic rclk = 1'b0;
    logic rrst_n = 1'b0;

    fifo_rd_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) bus ();

    fifo_rd_arbiter #(
        .NREQ       (NREQ),
        .MAX_BURST  (MAX_BURST),
        .DATA_WIDTH (DW)
    ) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    always #5 rclk = ~rclk;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO contents (write order) and the word returned this cycle.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_word;
    int            wr_cnt = 0;

    // Behavioural arbitration model.
    bit m_busy     = 0;
    int m_owner    = 0;
    int m_beats    = 0;
    int m_rr       = 0;
    bit m_pacc     = 0;
    int m_powner   = 0;
    bit pend_pop   = 0;

    // Last sampled DUT outputs, for directed literal checks.
    logic            samp_ren;
    logic            samp_val;
    logic [NREQ-1:0] samp_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare mid-cycle,
    // then advance the model using the inputs the next edge will sample.
    task automatic do_cycle(input logic [NREQ-1:0] req_v, input int npush, input bit rst_v);
        bit              acc;
        bit              m_ren;
        logic [NREQ-1:0] m_gnt;
        bit              found;
        int              idx;
        @(posedge rclk);
        #1;
        if (pend_pop) begin
            exp_word = fifo_q.pop_front();
            bus.r_data = exp_word;
        end else begin
            bus.r_data = DW'($urandom);
        end
        bus.empty = (fifo_q.size() == 0);
        for (int i = 0; i < npush; i++) begin
            if (fifo_q.size() < FIFO_CAP) begin
                fifo_q.push_back(DW'(wr_cnt));
                wr_cnt++;
            end
        end
        bus.req = req_v;
        rrst_n  = !rst_v;
        @(negedge rclk);
        samp_ren = bus.r_en;
        samp_val = bus.rd_valid;
        samp_gnt = bus.gnt;

        m_ren = m_busy && req_v[m_owner];
        m_gnt = m_busy ? NREQ'(1 << m_owner) : '0;
        if (rst_v) begin
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_gnt", 32'(bus.gnt), 0);
            check("rst_r_en", 32'(bus.r_en), 0);
            check("rst_rd_valid", 32'(bus.rd_valid), 0);
            check("rst_rd_id", 32'(bus.rd_id), 0);
            m_busy = 0; m_owner = 0; m_beats = 0; m_rr = 0;
            m_pacc = 0; m_powner = 0; pend_pop = 0;
            $display("[TB] cycle reset");
        end else begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("gnt", 32'(bus.gnt), 32'(m_gnt));
            check("r_en", 32'(bus.r_en), 32'(m_ren));
            check("rd_valid", 32'(bus.rd_valid), 32'(m_pacc));
            if (m_pacc) begin
                check("rd_id", 32'(bus.rd_id), 32'(m_powner));
                check("rd_data", 32'(bus.rd_data), 32'(exp_word));
                $display("[TB] return id=%0d data=%0h", m_powner, exp_word);
            end
            acc = m_ren && !bus.empty;
            if (acc) begin
                m_powner = m_owner;
            end
            if (!m_busy) begin
                if (req_v != 0 && !bus.empty) begin
                    found = 0;
                    for (int i = 0; i < NREQ; i++) begin
                        idx = (m_rr + i) % NREQ;
                        if (!found && req_v[idx]) begin
                            m_owner = idx;
                            found = 1;
                        end
                    end
                    m_beats = 0;
                    m_busy  = 1;
                end
            end else begin
                if (acc) m_beats++;
                if ((acc && m_beats == MAX_BURST) || !req_v[m_owner] || (bus.empty && !acc)) begin
                    m_busy = 0;
                    m_rr   = (m_owner + 1) % NREQ;
                end
            end
            m_pacc   = acc;
            pend_pop = acc;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ren_exp[10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
        int val_exp[10] = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 0};
        logic [NREQ-1:0] req_r;
        int rate;
        int npush;
        bit rst_v;

        bus.req    = '0;
        bus.empty  = 1'b1;
        bus.r_data = '0;

        // Reset, then single requester draining six words.
        do_cycle('0, 0, 1);
        do_cycle('0, 0, 1);
        do_cycle('0, 6, 0);
        for (int c = 0; c < 10; c++) begin
            do_cycle(4'b0001, 0, 0);
            check($sformatf("single_r_en_c%0d", c), 32'(samp_ren), 32'(ren_exp[c]));
            check($sformatf("single_rd_valid_c%0d", c), 32'(samp_val), 32'(val_exp[c]));
        end

        // Reset, then req=0110 with eight words: owner 1 first, then owner 2.
        do_cycle('0, 0, 1);
        do_cycle('0, 8, 0);
        for (int c = 0; c < 12; c++) begin
            do_cycle(4'b0110, 0, 0);
            if (c == 1) check("rr_first_gnt", 32'(samp_gnt), 32'(4'b0010));
            if (c == 5) check("rr_gap_gnt", 32'(samp_gnt), 32'(4'b0000));
            if (c == 6) check("rr_second_gnt", 32'(samp_gnt), 32'(4'b0100));
        end

        // Randomised traffic with persistent requests and varying fill rates.
        req_r = '0;
        for (int c = 0; c < 3000; c++) begin
            case ((c / 500) % 3)
                0:       rate = 20;
                1:       rate = 50;
                default: rate = 90;
            endcase
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 7) == 0) req_r[b] = ~req_r[b];
            end
            npush = ($urandom_range(0, 99) < rate) ? 1 : 0;
            rst_v = ($urandom_range(0, 599) == 0);
            do_cycle(req_r, npush, rst_v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
